// File: rtl/ma_pkg.sv
// Shared types and constants for the RV32I MEM stage.
// Optional byte-lane steering is enabled by defining MA_BYTE_LANE_EN.
package ma_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        mem_to_reg;
    logic [1:0]  rw_sel;
    logic [31:0] pc_plus_4;
    logic [31:0] read_data;
    logic [31:0] result;
    logic [4:0]  reg_dest;
    logic        reg_wr;
  } mem_wb_t;

  // The unused 2'b11 size code is treated as a word access.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    logic [1:0] sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// EX/MEM inputs, data-memory port and MEM/WB outputs of the MEM stage.
// slave = the MEM stage itself, master = the surrounding pipeline/memory.
interface memory_access_if;
  logic        i_clk_en;
  logic [31:0] i_data_rd;
  logic        i_ex_mem_to_reg;
  logic [1:0]  i_ex_rw_sel;
  logic        i_ex_reg_wr;
  logic        i_ex_mem_rd;
  logic        i_ex_mem_wr;
  logic [31:0] i_ex_pc_plus_4;
  logic [31:0] i_ex_alu_result;
  logic [31:0] i_ex_reg_read_data2;
  logic [4:0]  i_ex_reg_dest;
  logic [2:0]  i_ex_funct3;
  logic [6:0]  i_ex_funct7;
  logic [31:0] o_data_wr;
  logic [31:0] o_data_addr;
  logic [1:0]  o_data_rd_en_ctrl;
  logic        o_data_rd_en_ma;
  logic        o_data_wr_en_ma;
  logic        o_ma_mem_to_reg;
  logic [1:0]  o_ma_rw_sel;
  logic [31:0] o_ma_pc_plus_4;
  logic [31:0] o_ma_read_data;
  logic [31:0] o_ma_result;
  logic [4:0]  o_ma_reg_dest;
  logic        o_ma_reg_wr;

  modport slave (
    input  i_clk_en, i_data_rd, i_ex_mem_to_reg, i_ex_rw_sel, i_ex_reg_wr,
           i_ex_mem_rd, i_ex_mem_wr, i_ex_pc_plus_4, i_ex_alu_result,
           i_ex_reg_read_data2, i_ex_reg_dest, i_ex_funct3, i_ex_funct7,
    output o_data_wr, o_data_addr, o_data_rd_en_ctrl, o_data_rd_en_ma,
           o_data_wr_en_ma, o_ma_mem_to_reg, o_ma_rw_sel, o_ma_pc_plus_4,
           o_ma_read_data, o_ma_result, o_ma_reg_dest, o_ma_reg_wr
  );

  modport master (
    output i_clk_en, i_data_rd, i_ex_mem_to_reg, i_ex_rw_sel, i_ex_reg_wr,
           i_ex_mem_rd, i_ex_mem_wr, i_ex_pc_plus_4, i_ex_alu_result,
           i_ex_reg_read_data2, i_ex_reg_dest, i_ex_funct3, i_ex_funct7,
    input  o_data_wr, o_data_addr, o_data_rd_en_ctrl, o_data_rd_en_ma,
           o_data_wr_en_ma, o_ma_mem_to_reg, o_ma_rw_sel, o_ma_pc_plus_4,
           o_ma_read_data, o_ma_result, o_ma_reg_dest, o_ma_reg_wr
  );
endinterface

// File: rtl/ma_load_ext.sv
// Load-data extractor: picks the byte/half lane and sign/zero-extends it.
// Lane steering by address is active only with MA_BYTE_LANE_EN defined.
module ma_load_ext
  import ma_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

`ifdef MA_BYTE_LANE_EN
  // Lane selection from the low address bits
  always_comb begin
    byte_s = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end
`else
  logic unused_addr_s;
  assign unused_addr_s = ^addr_lo;
  assign byte_s        = rdata[7:0];
  assign half_s        = rdata[15:0];
`endif

  // Width/sign extension; reserved encodings pass the word through
  always_comb begin
    ext_data = rdata;
    case (funct3)
      LB:      ext_data = {{24{byte_s[7]}}, byte_s};
      LH:      ext_data = {{16{half_s[15]}}, half_s};
      LW:      ext_data = rdata;
      LBU:     ext_data = {24'h00_0000, byte_s};
      LHU:     ext_data = {16'h0000, half_s};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV32I MEM stage: combinational data-memory drive plus the MEM/WB register bank.
// Define MA_BYTE_LANE_EN for address-steered load lanes and replicated store data.
module memory_access
  import ma_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  memory_access_if.slave  bus
);

  logic [31:0] ext_data_s;
  logic [31:0] store_data_s;
  mem_wb_t     wb_r;
  logic        unused_s;

  assign unused_s = ^bus.i_ex_funct7;

  ma_load_ext u_load_ext (
    .funct3   (bus.i_ex_funct3),
    .addr_lo  (bus.i_ex_alu_result[1:0]),
    .rdata    (bus.i_data_rd),
    .ext_data (ext_data_s)
  );

`ifdef MA_BYTE_LANE_EN
  // Sub-word stores are replicated so the memory can pick any lane
  always_comb begin
    store_data_s = bus.i_ex_reg_read_data2;
    case (bus.i_ex_funct3)
      SB:      store_data_s = {4{bus.i_ex_reg_read_data2[7:0]}};
      SH:      store_data_s = {2{bus.i_ex_reg_read_data2[15:0]}};
      default: store_data_s = bus.i_ex_reg_read_data2;
    endcase
  end
`else
  assign store_data_s = bus.i_ex_reg_read_data2;
`endif

  assign bus.o_data_addr       = bus.i_ex_alu_result;
  assign bus.o_data_wr         = store_data_s;
  assign bus.o_data_rd_en_ma   = bus.i_ex_mem_rd;
  assign bus.o_data_wr_en_ma   = bus.i_ex_mem_wr;
  assign bus.o_data_rd_en_ctrl = access_size(bus.i_ex_funct3);

  // MEM/WB bank: load data is captured even for non-loads
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_r <= '0;
    end else if (bus.i_clk_en) begin
      wb_r.mem_to_reg <= bus.i_ex_mem_to_reg;
      wb_r.rw_sel     <= bus.i_ex_rw_sel;
      wb_r.pc_plus_4  <= bus.i_ex_pc_plus_4;
      wb_r.read_data  <= ext_data_s;
      wb_r.result     <= bus.i_ex_alu_result;
      wb_r.reg_dest   <= bus.i_ex_reg_dest;
      wb_r.reg_wr     <= bus.i_ex_reg_wr;
    end else begin
      wb_r <= wb_r;
    end
  end

  assign bus.o_ma_mem_to_reg = wb_r.mem_to_reg;
  assign bus.o_ma_rw_sel     = wb_r.rw_sel;
  assign bus.o_ma_pc_plus_4  = wb_r.pc_plus_4;
  assign bus.o_ma_read_data  = wb_r.read_data;
  assign bus.o_ma_result     = wb_r.result;
  assign bus.o_ma_reg_dest   = wb_r.reg_dest;
  assign bus.o_ma_reg_wr     = wb_r.reg_wr;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed spec cases, async reset, hold, random traffic.
module tb_memory_access;

  typedef struct {
    logic        m2r;
    logic [1:0]  rws;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        regwr;
  } wb_exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  wb_exp_t exp_q[$];
  wb_exp_t exp_hold;

  memory_access_if bus ();

  memory_access dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference: shift the addressed lane down, then extend by value arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    int unsigned sh;
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] h;
    sh = 0;
`ifdef MA_BYTE_LANE_EN
    if (f3[0]) sh = 16 * int'(a[1]);
    else       sh = 8 * int'(a);
`endif
    v = rd >> sh;
    b = v[7:0];
    h = v[15:0];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return v % 32'd256;
      3'd5:    return v % 32'd65536;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] rs2);
`ifdef MA_BYTE_LANE_EN
    if (f3[1:0] == 2'd0) return (rs2 % 32'd256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (rs2 % 32'd65536) * 32'h0001_0001;
`endif
    return rs2;
  endfunction

  task automatic check_regs_zero();
    chk("rst_m2r",    32'(bus.o_ma_mem_to_reg), 32'd0);
    chk("rst_rws",    32'(bus.o_ma_rw_sel),     32'd0);
    chk("rst_pc4",    bus.o_ma_pc_plus_4,       32'd0);
    chk("rst_rdata",  bus.o_ma_read_data,       32'd0);
    chk("rst_result", bus.o_ma_result,          32'd0);
    chk("rst_dest",   32'(bus.o_ma_reg_dest),   32'd0);
    chk("rst_regwr",  32'(bus.o_ma_reg_wr),     32'd0);
  endtask

  // One stage cycle: drive at negedge, check memory side, queue the WB expectation.
  task automatic drive(input logic rst_v, input logic en, input logic [2:0] f3,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] pc4, input logic [4:0] dest, input logic m2r,
                       input logic [1:0] rws, input logic regwr, input logic mrd,
                       input logic mwr);
    wb_exp_t e;
    logic [1:0] sz;
    @(negedge i_clk);
    i_rst                   = rst_v;
    bus.i_clk_en            = en;
    bus.i_ex_funct3         = f3;
    bus.i_ex_funct7         = 7'($urandom);
    bus.i_data_rd           = rd;
    bus.i_ex_alu_result     = alu;
    bus.i_ex_reg_read_data2 = rs2;
    bus.i_ex_pc_plus_4      = pc4;
    bus.i_ex_reg_dest       = dest;
    bus.i_ex_mem_to_reg     = m2r;
    bus.i_ex_rw_sel         = rws;
    bus.i_ex_reg_wr         = regwr;
    bus.i_ex_mem_rd         = mrd;
    bus.i_ex_mem_wr         = mwr;
    #1;
    sz = (f3[1:0] == 2'd3) ? 2'd2 : f3[1:0];
    chk("addr",    bus.o_data_addr, alu);
    chk("wdata",   bus.o_data_wr, model_store(f3, rs2));
    chk("size",    32'(bus.o_data_rd_en_ctrl), 32'(sz));
    chk("rd_en",   32'(bus.o_data_rd_en_ma), 32'(mrd));
    chk("wr_en",   32'(bus.o_data_wr_en_ma), 32'(mwr));
    if (rst_v) begin
      check_regs_zero();
    end else if (en) begin
      e.m2r = m2r; e.rws = rws; e.pc4 = pc4; e.rdata = model_load(f3, alu[1:0], rd);
      e.result = alu; e.dest = dest; e.regwr = regwr;
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_cycle(input logic en);
    drive(1'b0, en, 3'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom),
          1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Monitor: each rising edge either loads, clears or holds the expected WB bundle.
  initial begin
    logic s_en, s_rst;
    exp_hold = '{1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0};
    forever begin
      @(posedge i_clk);
      s_en  = bus.i_clk_en;
      s_rst = i_rst;
      #1;
      if (s_rst) begin
        exp_hold = '{1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0};
      end else if (s_en) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_empty: got capture expected none queued at %0t", $time);
        end else begin
          exp_hold = exp_q.pop_front();
        end
      end
      chk("ma_m2r",    32'(bus.o_ma_mem_to_reg), 32'(exp_hold.m2r));
      chk("ma_rws",    32'(bus.o_ma_rw_sel),     32'(exp_hold.rws));
      chk("ma_pc4",    bus.o_ma_pc_plus_4,       exp_hold.pc4);
      chk("ma_rdata",  bus.o_ma_read_data,       exp_hold.rdata);
      chk("ma_result", bus.o_ma_result,          exp_hold.result);
      chk("ma_dest",   32'(bus.o_ma_reg_dest),   32'(exp_hold.dest));
      chk("ma_regwr",  32'(bus.o_ma_reg_wr),     32'(exp_hold.regwr));
    end
  end

  initial begin
    bus.i_clk_en = 1'b0; bus.i_data_rd = 32'd0; bus.i_ex_mem_to_reg = 1'b0;
    bus.i_ex_rw_sel = 2'd0; bus.i_ex_reg_wr = 1'b0; bus.i_ex_mem_rd = 1'b0;
    bus.i_ex_mem_wr = 1'b0; bus.i_ex_pc_plus_4 = 32'd0; bus.i_ex_alu_result = 32'd0;
    bus.i_ex_reg_read_data2 = 32'd0; bus.i_ex_reg_dest = 5'd0; bus.i_ex_funct3 = 3'd0;
    bus.i_ex_funct7 = 7'd0;
    // Reset held with enable high and live inputs: registers must stay zero.
    repeat (2) drive(1'b1, 1'b1, 3'd2, 32'h1111_2222, 32'h40, 32'h5, 32'h8, 5'd3,
                     1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    // Directed load / store cases
    drive(1'b0, 1'b1, 3'b000, 32'hFFFF_FF80, 32'h10, 32'h0, 32'h4, 5'd10,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 32'hFFFF_8000, 32'h20, 32'h0, 32'h8, 5'd11,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 32'h1234_5678, 32'h30, 32'h0, 32'hC, 5'd12,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b100, 32'h0000_00AB, 32'h40, 32'h0, 32'h10, 5'd13,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b101, 32'h0000_ABCD, 32'h50, 32'h0, 32'h14, 5'd14,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h1000_0000, 32'hCAFE_BABE, 32'h18, 5'd0,
          1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 3'b011, 32'h8765_4321, 32'h3, 32'h0, 32'h1C, 5'd31,
          1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 3'b111, 32'h8000_0001, 32'h2, 32'h0, 32'h20, 5'd1,
          1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    // Stage enable low with changing inputs: WB registers hold
    repeat (3) rand_cycle(1'b0);
    drive(1'b0, 1'b1, 3'b000, 32'h7F80_01FF, 32'h7, 32'h1234_56A5, 32'h24, 5'd7,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b101, 32'hF00D_8001, 32'h6, 32'h0, 32'h28, 5'd8,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    // Async reset mid-run: zeros right after assertion, before any edge
    drive(1'b1, 1'b1, 3'b010, 32'hAAAA_5555, 32'h44, 32'h66, 32'h2C, 5'd9,
          1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      rand_cycle(($urandom % 4) != 0);
    end
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0,
          1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
